// File: rtl/pix_gate_pkg.sv
// Shared definitions for the pixel frame gate.
//   PIX_W_DEF  : default bits per pixel
//   NUM_LANES  : pixels delivered per clock
//   FCNT_W     : completed-frame counter width
//   gate_state_t : frame gate FSM states
// Optional feature macro used by the top: PIX_GATE_TEST_PATTERN_EN.
package pix_gate_pkg;

  localparam int unsigned PIX_W_DEF = 10;
  localparam int unsigned NUM_LANES = 2;
  localparam int unsigned FCNT_W    = 16;

  typedef enum logic [2:0] {
    SYNC,
    IDLE,
    ARMED,
    ACTIVE,
    EOF
  } gate_state_t;

endpackage

// File: rtl/pix_roi_window.sv
// Combinational region-of-interest compare, one flag per lane.
// Ports:
//   col  : per-lane pixel column
//   row  : current row
//   x0/x1: inclusive column window (latched at frame start)
//   y0/y1: inclusive row window (latched at frame start)
//   mask : per-lane in-window flags
// An empty window (x0 > x1 or y0 > y1) yields an all-zero mask.
module pix_roi_window
  import pix_gate_pkg::*;
#(
  parameter int unsigned COL_W = 12,
  parameter int unsigned ROW_W = 12
) (
  input  logic [NUM_LANES-1:0][COL_W-1:0] col,
  input  logic [ROW_W-1:0]                row,
  input  logic [COL_W-1:0]                x0,
  input  logic [COL_W-1:0]                x1,
  input  logic [ROW_W-1:0]                y0,
  input  logic [ROW_W-1:0]                y1,
  output logic [NUM_LANES-1:0]            mask
);

  logic row_in;

  always_comb begin
    row_in = (row >= y0) && (row <= y1);
    mask   = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      mask[i] = row_in && (col[i] >= x0) && (col[i] <= x1);
    end
  end

endmodule

// File: rtl/pix_frame_gate.sv
// Pixel front-end gate: admits whole frames of a 2-pixel/clock stream,
// crops to a latched ROI, emits qualified beats with per-lane masks and
// frame markers, and flags line-length / row-count geometry errors.
// Ports:
//   clk, reset_n_i        : clock, synchronous active-low reset
//   cmos_data_i           : pixel pair, lane0 = low PIX_W bits (even column)
//   fv_i, lv_i            : frame valid, line valid
//   enable_i              : arm capture (acts at frame boundaries)
//   clr_err_i             : clear sticky error flags
//   roi_x0_i..roi_y1_i    : inclusive ROI, latched at frame start
//   tpg_sel_i             : test pattern select (PIX_GATE_TEST_PATTERN_EN only)
//   pix_data_o/mask/valid : registered output beat, masked lanes forced 0
//   sof_o, eof_o          : frame markers
//   frame_cnt_o           : completed gated frames (wraps)
//   err_line_len_o, err_row_cnt_o : sticky geometry errors
//   busy_o                : capturing a frame
// Macro PIX_GATE_TEST_PATTERN_EN adds tpg_sel_i; lane data then becomes
// (column + row) mod 2^PIX_W.
module pix_frame_gate
  import pix_gate_pkg::*;
#(
  parameter int unsigned PIX_W    = PIX_W_DEF,
  parameter int unsigned COL_W    = 12,
  parameter int unsigned ROW_W    = 12,
  parameter int unsigned EXP_COLS = 1280,
  parameter int unsigned EXP_ROWS = 800
) (
  input  logic                   clk,
  input  logic                   reset_n_i,
  input  logic [2*PIX_W-1:0]     cmos_data_i,
  input  logic                   fv_i,
  input  logic                   lv_i,
  input  logic                   enable_i,
  input  logic                   clr_err_i,
  input  logic [COL_W-1:0]       roi_x0_i,
  input  logic [COL_W-1:0]       roi_x1_i,
  input  logic [ROW_W-1:0]       roi_y0_i,
  input  logic [ROW_W-1:0]       roi_y1_i,
`ifdef PIX_GATE_TEST_PATTERN_EN
  input  logic                   tpg_sel_i,
`endif
  output logic [2*PIX_W-1:0]     pix_data_o,
  output logic [NUM_LANES-1:0]   pix_mask_o,
  output logic                   pix_valid_o,
  output logic                   sof_o,
  output logic                   eof_o,
  output logic [FCNT_W-1:0]      frame_cnt_o,
  output logic                   err_line_len_o,
  output logic                   err_row_cnt_o,
  output logic                   busy_o
);

  localparam logic [COL_W-2:0] LINE_BEATS = (COL_W-1)'(EXP_COLS / 2);
  localparam logic [ROW_W-1:0] FRAME_ROWS = ROW_W'(EXP_ROWS);

  gate_state_t state;

  logic fv_q, lv_q;
  logic fv_rise, fv_fall, lv_fall;
  logic beat_en;

  // Beat counter is one bit narrower than a column so 2*b+1 always fits.
  logic [COL_W-2:0] beat;
  logic [ROW_W-1:0] row, row_next;
  logic             sof_done;

  logic [COL_W-1:0] x0_q, x1_q;
  logic [ROW_W-1:0] y0_q, y1_q;

  logic [NUM_LANES-1:0][COL_W-1:0] col;
  logic [NUM_LANES-1:0]            mask_c;
  logic [NUM_LANES-1:0][PIX_W-1:0] data_c;
  logic [PIX_W-1:0]                lane_src;

  logic set_line_err, set_row_err;

  assign fv_rise = fv_i & ~fv_q;
  assign fv_fall = ~fv_i & fv_q;
  assign lv_fall = ~lv_i & lv_q;
  assign beat_en = (state == ACTIVE) && fv_i && lv_i;
  assign busy_o  = (state == ACTIVE);

  always_comb begin
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      col[i] = {beat, 1'(i)};
    end
  end

  pix_roi_window #(
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_roi (
    .col  (col),
    .row  (row),
    .x0   (x0_q),
    .x1   (x1_q),
    .y0   (y0_q),
    .y1   (y1_q),
    .mask (mask_c)
  );

  always_comb begin
    lane_src = '0;
    data_c   = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      lane_src = cmos_data_i[i*PIX_W +: PIX_W];
`ifdef PIX_GATE_TEST_PATTERN_EN
      if (tpg_sel_i) begin
        lane_src = PIX_W'(col[i]) + PIX_W'(row);
      end
`endif
      data_c[i] = mask_c[i] ? lane_src : '0;
    end
  end

  // Row count as it stands after this cycle's line end, so a simultaneous
  // fv/lv fall checks the row total including the line just closed.
  always_comb begin
    row_next = row;
    if (lv_fall && (row != '1)) begin
      row_next = row + 1'b1;
    end
  end

  assign set_line_err = (state == ACTIVE) && lv_fall && (beat != LINE_BEATS);
  assign set_row_err  = (state == ACTIVE) && fv_fall && (row_next != FRAME_ROWS);

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      state          <= SYNC;
      fv_q           <= 1'b0;
      lv_q           <= 1'b0;
      beat           <= '0;
      row            <= '0;
      sof_done       <= 1'b0;
      x0_q           <= '0;
      x1_q           <= '0;
      y0_q           <= '0;
      y1_q           <= '0;
      pix_data_o     <= '0;
      pix_mask_o     <= '0;
      pix_valid_o    <= 1'b0;
      sof_o          <= 1'b0;
      eof_o          <= 1'b0;
      frame_cnt_o    <= '0;
      err_line_len_o <= 1'b0;
      err_row_cnt_o  <= 1'b0;
    end else begin
      fv_q        <= fv_i;
      lv_q        <= lv_i;
      pix_data_o  <= '0;
      pix_mask_o  <= '0;
      pix_valid_o <= 1'b0;
      sof_o       <= 1'b0;
      eof_o       <= 1'b0;

      // Set has priority over clear.
      if (set_line_err) begin
        err_line_len_o <= 1'b1;
      end else if (clr_err_i) begin
        err_line_len_o <= 1'b0;
      end
      if (set_row_err) begin
        err_row_cnt_o <= 1'b1;
      end else if (clr_err_i) begin
        err_row_cnt_o <= 1'b0;
      end

      case (state)
        SYNC: begin
          if (!fv_i) state <= IDLE;
        end
        IDLE: begin
          if (enable_i) state <= ARMED;
        end
        ARMED: begin
          if (!enable_i) begin
            state <= IDLE;
          end else if (fv_rise) begin
            x0_q     <= roi_x0_i;
            x1_q     <= roi_x1_i;
            y0_q     <= roi_y0_i;
            y1_q     <= roi_y1_i;
            row      <= '0;
            beat     <= '0;
            sof_done <= 1'b0;
            state    <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (beat_en) begin
            pix_valid_o <= |mask_c;
            pix_mask_o  <= mask_c;
            pix_data_o  <= data_c;
            if ((|mask_c) && !sof_done) begin
              sof_o    <= 1'b1;
              sof_done <= 1'b1;
            end
            if (beat != '1) beat <= beat + 1'b1;
          end
          if (lv_fall) begin
            row  <= row_next;
            beat <= '0;
          end
          if (fv_fall) begin
            eof_o       <= 1'b1;
            frame_cnt_o <= frame_cnt_o + 1'b1;
            state       <= EOF;
          end
        end
        EOF: begin
          state <= enable_i ? ARMED : IDLE;
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_pix_frame_gate.sv
// Directed bench for pix_frame_gate with a reduced geometry (8x4 frames).
// The driver knows which frames are captured and what each beat must look
// like; it posts the expected outputs for every cycle, and a single compare
// process checks them one clock later.
module tb_pix_frame_gate;
  import pix_gate_pkg::*;

  localparam int EXP_COLS = 8;
  localparam int EXP_ROWS = 4;
  localparam int BMAX     = 2047;
  localparam int RMAX     = 4095;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic [19:0] cmos_data_i;
  logic        fv_i, lv_i, enable_i, clr_err_i;
  logic [11:0] roi_x0_i, roi_x1_i, roi_y0_i, roi_y1_i;
  logic        tpg_sel = 1'b0;
  logic [19:0] pix_data_o;
  logic [1:0]  pix_mask_o;
  logic        pix_valid_o, sof_o, eof_o;
  logic [15:0] frame_cnt_o;
  logic        err_line_len_o, err_row_cnt_o, busy_o;

  always #5 clk = ~clk;

  pix_frame_gate #(
    .PIX_W    (10),
    .COL_W    (12),
    .ROW_W    (12),
    .EXP_COLS (EXP_COLS),
    .EXP_ROWS (EXP_ROWS)
  ) dut (
    .clk            (clk),
    .reset_n_i      (reset_n_i),
    .cmos_data_i    (cmos_data_i),
    .fv_i           (fv_i),
    .lv_i           (lv_i),
    .enable_i       (enable_i),
    .clr_err_i      (clr_err_i),
    .roi_x0_i       (roi_x0_i),
    .roi_x1_i       (roi_x1_i),
    .roi_y0_i       (roi_y0_i),
    .roi_y1_i       (roi_y1_i),
`ifdef PIX_GATE_TEST_PATTERN_EN
    .tpg_sel_i      (tpg_sel),
`endif
    .pix_data_o     (pix_data_o),
    .pix_mask_o     (pix_mask_o),
    .pix_valid_o    (pix_valid_o),
    .sof_o          (sof_o),
    .eof_o          (eof_o),
    .frame_cnt_o    (frame_cnt_o),
    .err_line_len_o (err_line_len_o),
    .err_row_cnt_o  (err_row_cnt_o),
    .busy_o         (busy_o)
  );

  typedef struct {
    bit          chk;
    bit          valid;
    logic [1:0]  mask;
    logic [19:0] data;
    bit          sof;
    bit          eof;
    bit          busy;
    int          fc;
    bit          ell;
    bit          erc;
  } exp_t;

  exp_t exp_pend, exp_cur;
  int   n_checks = 0;
  int   n_fail   = 0;

  // model state
  int m_fc = 0;
  bit m_ell = 0, m_erc = 0;
  bit sof_pend = 0;
  int lx0, lx1, ly0, ly1;

  // observation counters for literal checks
  int         cnt_valid = 0, cnt_sof = 0, cnt_eof = 0;
  logic [1:0] vmask[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic exp_t base();
    exp_t e;
    e.chk = 1; e.valid = 0; e.mask = '0; e.data = '0;
    e.sof = 0; e.eof = 0; e.busy = 0;
    e.fc = m_fc; e.ell = m_ell; e.erc = m_erc;
    return e;
  endfunction

  initial begin
    exp_pend = base();
    exp_pend.chk = 0;
    exp_cur  = exp_pend;
  end

  always @(posedge clk) exp_cur = exp_pend;

  always @(negedge clk) begin
    if (exp_cur.chk) begin
      check("pix_valid", 32'(pix_valid_o), 32'(exp_cur.valid));
      check("pix_mask", 32'(pix_mask_o), 32'(exp_cur.mask));
      check("pix_data", 32'(pix_data_o), 32'(exp_cur.data));
      check("sof", 32'(sof_o), 32'(exp_cur.sof));
      check("eof", 32'(eof_o), 32'(exp_cur.eof));
      check("busy", 32'(busy_o), 32'(exp_cur.busy));
      check("frame_cnt", 32'(frame_cnt_o), exp_cur.fc);
      check("err_line_len", 32'(err_line_len_o), 32'(exp_cur.ell));
      check("err_row_cnt", 32'(err_row_cnt_o), 32'(exp_cur.erc));
      if (pix_valid_o) begin
        cnt_valid++;
        vmask.push_back(pix_mask_o);
      end
      if (sof_o) cnt_sof++;
      if (eof_o) cnt_eof++;
    end
  end

  task automatic drive(input bit fv, input bit lv, input logic [19:0] d, input exp_t e);
    fv_i = fv; lv_i = lv; cmos_data_i = d; exp_pend = e;
    @(posedge clk); #1;
  endtask

  task automatic set_roi(input int x0, input int x1, input int y0, input int y1);
    roi_x0_i = 12'(x0); roi_x1_i = 12'(x1); roi_y0_i = 12'(y0); roi_y1_i = 12'(y1);
  endtask

  task automatic clear_obs();
    cnt_valid = 0; cnt_sof = 0; cnt_eof = 0;
    vmask.delete();
  endtask

  // Expected output for one captured beat at row r, beat index b.
  task automatic beat_exp(input int r, input int b, input logic [19:0] d, inout exp_t e);
    int bb, rr, c;
    bb = imin(b, BMAX);
    rr = imin(r, RMAX);
    for (int i = 0; i < 2; i++) begin
      c = 2 * bb + i;
      e.mask[i] = (c >= lx0) && (c <= lx1) && (rr >= ly0) && (rr <= ly1);
      e.data[i*10 +: 10] = e.mask[i] ? d[i*10 +: 10] : 10'd0;
    end
    e.valid = |e.mask;
    if (e.valid && sof_pend) begin
      e.sof = 1;
      sof_pend = 0;
    end
  endtask

  task automatic gap(input int n, input bit lvpulse);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, lvpulse && (k > 0) && (k < n - 1), 20'(k * 7), base());
    end
  endtask

  task automatic clr_pulse();
    clr_err_i = 1;
    m_ell = 0; m_erc = 0;
    drive(1'b0, 1'b0, '0, base());
    clr_err_i = 0;
  endtask

  task automatic frame(input int nrows, input int beats, input int odd_row,
                       input int odd_beats, input bit cap, input bit join_end,
                       input bit clr_end, input int en_row, input bit en_val,
                       input int roi_row);
    exp_t e;
    int nb;
    bit last_bad;
    logic [19:0] d;
    last_bad = 0;
    if (cap) begin
      lx0 = int'(roi_x0_i); lx1 = int'(roi_x1_i);
      ly0 = int'(roi_y0_i); ly1 = int'(roi_y1_i);
      sof_pend = 1;
    end
    e = base(); e.busy = cap;
    drive(1'b1, 1'b0, '0, e);
    for (int r = 0; r < nrows; r++) begin
      if (r == en_row) enable_i = en_val;
      if (r == roi_row) set_roi(0, 4095, 0, 4095);
      nb = (r == odd_row) ? odd_beats : beats;
      for (int b = 0; b < nb; b++) begin
        d = 20'($urandom);
        e = base(); e.busy = cap;
        if (cap) beat_exp(r, b, d, e);
        drive(1'b1, 1'b1, d, e);
      end
      last_bad = (nb != EXP_COLS / 2);
      if (cap && last_bad) m_ell = 1;
      if (!(join_end && r == nrows - 1)) begin
        e = base(); e.busy = cap;
        drive(1'b1, 1'b0, '0, e);
        e = base(); e.busy = cap;
        drive(1'b1, 1'b0, '0, e);
      end
    end
    if (clr_end) begin
      clr_err_i = 1;
      m_ell = cap && join_end && last_bad;
      m_erc = 0;
    end
    if (cap) begin
      if (imin(nrows, RMAX) != EXP_ROWS) m_erc = 1;
      m_fc = (m_fc + 1) & 16'hFFFF;
    end
    e = base(); e.eof = cap;
    drive(1'b0, 1'b0, '0, e);
    clr_err_i = 0;
    drive(1'b0, 1'b0, '0, base());
  endtask

  int n_bad;

  initial begin
    reset_n_i = 0; fv_i = 0; lv_i = 0; cmos_data_i = '0;
    enable_i = 0; clr_err_i = 0;
    set_roi(0, 0, 0, 0);
    @(posedge clk); #1;
    repeat (4) drive(1'b0, 1'b0, '0, base());
    reset_n_i = 1;
    check("rst_frame_cnt", 32'(frame_cnt_o), 32'd0);
    check("rst_valid", 32'(pix_valid_o), 32'd0);
    check("rst_errs", 32'({err_line_len_o, err_row_cnt_o, busy_o}), 32'd0);
    gap(4, 1'b0);

    // Enable raised mid-frame: that frame is skipped, the next is captured.
    set_roi(0, 7, 0, 3);
    clear_obs();
    frame(4, 4, -1, 0, 1'b0, 1'b0, 1'b0, 2, 1'b1, -1);
    gap(6, 1'b1);
    check("midframe_en_beats", 32'(cnt_valid), 32'd0);
    check("midframe_en_fc", 32'(frame_cnt_o), 32'd0);

    // Full-ROI frame.
    clear_obs();
    frame(4, 4, -1, 0, 1'b1, 1'b0, 1'b0, -1, 1'b0, -1);
    gap(4, 1'b0);
    n_bad = 0;
    foreach (vmask[i]) if (vmask[i] != 2'b11) n_bad++;
    check("full_beats", 32'(cnt_valid), 32'd16);
    check("full_masks_not11", 32'(n_bad), 32'd0);
    check("full_sof", 32'(cnt_sof), 32'd1);
    check("full_eof", 32'(cnt_eof), 32'd1);
    check("full_fc", 32'(frame_cnt_o), 32'd1);
    check("full_errs", 32'({err_line_len_o, err_row_cnt_o}), 32'd0);

    // Small ROI; ROI inputs change mid-frame and must be ignored.
    set_roi(3, 6, 2, 2);
    clear_obs();
    frame(4, 4, -1, 0, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1);
    gap(4, 1'b0);
    check("roi_beats", 32'(cnt_valid), 32'd3);
    if (vmask.size() == 3) begin
      check("roi_mask_b1", 32'(vmask[0]), 32'h2);
      check("roi_mask_b2", 32'(vmask[1]), 32'h3);
      check("roi_mask_b3", 32'(vmask[2]), 32'h1);
    end
    check("roi_sof", 32'(cnt_sof), 32'd1);

    // Short line sets the sticky line-length flag.
    set_roi(0, 7, 0, 3);
    frame(4, 4, 1, 3, 1'b1, 1'b0, 1'b0, -1, 1'b0, -1);
    gap(4, 1'b0);
    check("short_line_err", 32'(err_line_len_o), 32'd1);
    frame(4, 4, -1, 0, 1'b1, 1'b0, 1'b0, -1, 1'b0, -1);
    gap(4, 1'b0);
    check("short_line_sticky", 32'(err_line_len_o), 32'd1);
    clr_pulse();
    gap(3, 1'b0);
    check("short_line_clr", 32'(err_line_len_o), 32'd0);
    check("short_line_fc", 32'(frame_cnt_o), 32'd4);

    // Missing row.
    clear_obs();
    frame(3, 4, -1, 0, 1'b1, 1'b0, 1'b0, -1, 1'b0, -1);
    gap(4, 1'b0);
    check("row_err", 32'(err_row_cnt_o), 32'd1);
    check("row_err_eof", 32'(cnt_eof), 32'd1);
    clr_pulse();
    gap(3, 1'b0);

    // lv and fv fall together, clear coincident with row error.
    frame(3, 4, 0, 3, 1'b1, 1'b1, 1'b1, -1, 1'b0, -1);
    gap(4, 1'b0);
    check("join_row_err_wins", 32'(err_row_cnt_o), 32'd1);
    check("join_line_cleared", 32'(err_line_len_o), 32'd0);
    clr_pulse();
    gap(3, 1'b0);

    // Empty ROI: no sof, frame still counted.
    set_roi(5, 2, 0, 3);
    clear_obs();
    frame(4, 4, -1, 0, 1'b1, 1'b0, 1'b0, -1, 1'b0, -1);
    gap(4, 1'b0);
    check("empty_sof", 32'(cnt_sof), 32'd0);
    check("empty_eof", 32'(cnt_eof), 32'd1);
    check("empty_fc", 32'(frame_cnt_o), 32'd7);

    // Enable dropped mid-frame: frame completes, next frame is not gated.
    set_roi(0, 7, 0, 3);
    clear_obs();
    frame(4, 4, -1, 0, 1'b1, 1'b0, 1'b0, 2, 1'b0, -1);
    gap(4, 1'b0);
    check("drop_beats", 32'(cnt_valid), 32'd16);
    clear_obs();
    frame(4, 4, -1, 0, 1'b0, 1'b0, 1'b0, -1, 1'b0, -1);
    gap(4, 1'b0);
    check("drop_next_beats", 32'(cnt_valid), 32'd0);
    check("drop_next_fc", 32'(frame_cnt_o), 32'd8);
    check("drop_busy", 32'(busy_o), 32'd0);

    // Beat counter saturation.
    enable_i = 1;
    set_roi(4094, 4095, 0, 4095);
    gap(4, 1'b0);
    clear_obs();
    frame(1, 2100, -1, 0, 1'b1, 1'b0, 1'b0, -1, 1'b0, -1);
    gap(4, 1'b0);
    check("col_sat_beats", 32'(cnt_valid), 32'd53);
    clr_pulse();
    gap(3, 1'b0);

    // Row counter saturation.
    set_roi(0, 1, 4094, 4095);
    clear_obs();
    frame(4100, 1, -1, 0, 1'b1, 1'b0, 1'b0, -1, 1'b0, -1);
    gap(4, 1'b0);
    check("row_sat_beats", 32'(cnt_valid), 32'd6);
    check("row_sat_fc", 32'(frame_cnt_o), 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
